bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
Sequential, area-minimal adder that reuses one single-bit add cell: a full add built from two half-add stages plus a carry flip-flop, over WIDTH clock cycles, LSB first.
It sits directly downstream of the team's single-bit half-add cell and consumes its sum/carry outputs each cycle.
It sequences operands into that cell and assembles a parallel WIDTH-bit result with a start/done handshake.
Intended as the multi-bit wrapper for the adder cell in later datapath blocks.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
start  input  1  request pulse; accepted only when not busy.
A  input  WIDTH  operand A, sampled on the accepting edge only.
B  input  WIDTH  operand B, sampled on the accepting edge only.
Cin  input  1  carry-in, sampled on the accepting edge only.
busy  output  1  high while an addition is in progress.
done  output  1  single-cycle pulse: Y/Cout hold the new result.
Y  output  WIDTH  sum result, registered, held until next completion.
Cout  output  1  carry-out of bit WIDTH-1, registered, held with Y.

Behaviour:
- Reset: one clock, synchronous, active-low. The design has one clock domain only.
- Reset values: state=IDLE, busy=0, done=0, Y=0, Cout=0, internal shift registers/carry/bit counter=0.
- Reset asserted mid-operation aborts the add and returns to reset values on that edge. No done is issued for the aborted add.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge:
  - latch A, B into shift registers and Cin into the carry flop;
  - set bit_cnt=0;
  - go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - sum_bit = a0 ^ b0 ^ carry; carry <= (a0&b0) | (carry&(a0^b0)). This is the two half-add stages plus OR.
  - shift sum_bit into the result register MSB, so after WIDTH shifts bit 0 sits at the LSB.
  - shift the operand registers right; increment bit_cnt.
- RUN, edge where bit_cnt==WIDTH-1:
  - Y <= completed result and Cout <= final carry;
  - go to DONE; busy <= 0; done <= 1.
- DONE: done high for exactly one cycle. On the next edge go to IDLE with done=0, unless start=1, in which case take the IDLE/DONE start path above.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH. That is WIDTH+1 edges from accept to the done-visible cycle. Throughput is one add per WIDTH+1 cycles with back-to-back starts.
- start while busy (RUN) is ignored. Operands and Cin are not resampled, and the in-flight result is unaffected.
- Y and Cout change only on a completion edge (or reset). They are stable during RUN and show the previous result.
- Arithmetic: {Cout,Y} = A + B + Cin, modulo 2^(WIDTH+1). There is no overflow flag.
- WIDTH=1: RUN lasts one edge; done appears in the cycle after edge 1.
- Inputs A, B, Cin are don't-care outside the accepting edge.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → busy=0, done=0, Y=0x00, Cout=0 throughout. Release → IDLE, then the start is accepted on the next edge.
- Basic add, WIDTH=8: A=0x0F, B=0x01, Cin=0, 1-cycle start → busy high 8 cycles, done pulses one cycle at edge 9, Y=0x10, Cout=0.
- Carry ripple/wrap: A=0xFF, B=0x01, Cin=0 → Y=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 → Y=0xFF, Cout=1.
- Start while busy: start A=0x05, B=0x03. At cycle 3 pulse start with A=0xAA, B=0x55 → ignored; done once with Y=0x08, Cout=0. Y stays 0x08 afterwards.
- Back-to-back and reset abort: assert start in the DONE cycle with A=0x80, B=0x80 → accepted, next done gives Y=0x00, Cout=1. Start another add, drop rst_n at cycle 4 → no done, all outputs 0.
- Random/exhaustive: WIDTH=4 all 512 (A, B, Cin) combinations, and WIDTH=1 all 8 → {Cout,Y} equals A+B+Cin for each. done is exactly one cycle per accepted start.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-add cell (two half-add stages plus a carry
// flop) reused over WIDTH cycles, LSB first, with a start/done handshake.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             last;
  logic             h1_s, h1_c;
  logic             h2_s, h2_c;
  logic             carry_nx;
  logic [WIDTH-1:0] acc_shift;

  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) &&
                  (cnt_q == CW'(WIDTH - 1));

  // First half-add on the operand bits, second folds in the carry.
  assign h1_s     = a_q[0] ^ b_q[0];
  assign h1_c     = a_q[0] & b_q[0];
  assign h2_s     = h1_s ^ carry_q;
  assign h2_c     = h1_s & carry_q;
  assign carry_nx = h1_c | h2_c;

  always_comb begin
    acc_shift            = acc_q >> 1;
    acc_shift[WIDTH-1]   = h2_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = start ? RUN : IDLE;
      RUN:        if (last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    y_d     = y_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      carry_d = Cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = carry_nx;
      acc_d   = acc_shift;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        y_d    = acc_shift;
        cout_d = carry_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
    end
  end

  assign Y    = y_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized and exhaustive bench for bit_serial_adder at WIDTH 8, 4, 1
// against plain A+B+Cin arithmetic.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8 = 0, c8 = 0, bz8, dn8, co8;
  logic [7:0] a8 = 0, b8 = 0, y8;
  logic       st4 = 0, c4 = 0, bz4, dn4, co4;
  logic [3:0] a4 = 0, b4 = 0, y4;
  logic       st1 = 0, c1 = 0, bz1, dn1, co1;
  logic [0:0] a1 = 0, b1 = 0, y1;

  int nvec = 0;
  int nbad = 0;

  bit_serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8),
    .Cin(c8), .busy(bz8), .done(dn8), .Y(y8), .Cout(co8));
  bit_serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4),
    .Cin(c4), .busy(bz4), .done(dn4), .Y(y4), .Cout(co4));
  bit_serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1),
    .Cin(c1), .busy(bz1), .done(dn1), .Y(y1), .Cout(co1));

  function automatic logic [8:0] model(input int w,
    input logic [7:0] a, input logic [7:0] b, input logic ci);
    int s;
    int m;
    m = (1 << (w + 1)) - 1;
    s = (int'(a) & ((1 << w) - 1)) + (int'(b) & ((1 << w) - 1)) + int'(ci);
    return 9'(s & m);
  endfunction

  // Stimulus only: one start pulse, then watch for w+4 cycles.
  task automatic run(input int w, input logic [7:0] a,
    input logic [7:0] b, input logic ci,
    output logic [8:0] res, output int lat,
    output int dcnt, output int bcnt);
    logic d, bz;
    @(negedge clk);
    case (w)
      8: begin a8 = a; b8 = b; c8 = ci; st8 = 1; end
      4: begin a4 = a[3:0]; b4 = b[3:0]; c4 = ci; st4 = 1; end
      default: begin a1 = a[0]; b1 = b[0]; c1 = ci; st1 = 1; end
    endcase
    @(posedge clk);
    #1;
    st8 = 0; st4 = 0; st1 = 0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom);
    res = '0; lat = -1; dcnt = 0; bcnt = 0;
    for (int k = 1; k <= w + 4; k++) begin
      @(negedge clk);
      case (w)
        8: begin d = dn8; bz = bz8; end
        4: begin d = dn4; bz = bz4; end
        default: begin d = dn1; bz = bz1; end
      endcase
      if (bz) bcnt++;
      if (d) begin
        dcnt++;
        if (lat < 0) begin
          lat = k;
          case (w)
            8: res = {co8, y8};
            4: res = {4'd0, co4, y4};
            default: res = {7'd0, co1, y1};
          endcase
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    a8 = 8'h12; b8 = 8'h34; c8 = 1; st8 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if ({bz8, dn8, co8, y8} !== 11'd0) begin
        nbad++;
        $display("FAIL reset_hold: got busy/done/cout/y=%b want 0",
                 {bz8, dn8, co8, y8});
      end
    end
    rst_n = 1;
    @(posedge clk);
    #1 st8 = 0;
    @(negedge clk);
    nvec++;
    if (bz8 !== 1'b1) begin
      nbad++;
      $display("FAIL reset_release_accept: busy=%b want 1", bz8);
    end
    for (int k = 0; k < 12 && dn8 !== 1'b1; k++) @(negedge clk);
    nvec++;
    if (dn8 !== 1'b1 || {co8, y8} !== 9'h047) begin
      nbad++;
      $display("FAIL reset_first_add: done=%b res=%h want 1/047",
               dn8, {co8, y8});
    end
    @(negedge clk);
  endtask

  task automatic check8(input string nm, input logic [7:0] a,
    input logic [7:0] b, input logic ci);
    logic [8:0] r, e;
    int lat, dc, bc;
    e = model(8, a, b, ci);
    run(8, a, b, ci, r, lat, dc, bc);
    nvec++;
    if (r !== e || lat != 9 || dc != 1 || bc != 8) begin
      nbad++;
      $display("FAIL %s: res=%h lat=%0d done=%0d busy=%0d want %h/9/1/8",
               nm, r, lat, dc, bc, e);
    end
  endtask

  task automatic test_basic();
    check8("basic_0f_01", 8'h0F, 8'h01, 1'b0);
  endtask

  task automatic test_carry();
    check8("carry_ff_01", 8'hFF, 8'h01, 1'b0);
    check8("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_busy_ignore();
    int dc;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; c8 = 0; st8 = 1;
    @(posedge clk);
    #1 st8 = 0;
    dc = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) begin
        a8 = 8'hAA; b8 = 8'h55; c8 = 1; st8 = 1;
      end else begin
        st8 = 0;
      end
      if (dn8) begin
        dc++;
        nvec++;
        if (k != 9 || {co8, y8} !== 9'h008) begin
          nbad++;
          $display("FAIL busy_ignore_done: k=%0d res=%h want 9/008",
                   k, {co8, y8});
        end
      end
    end
    nvec++;
    if (dc != 1 || {co8, y8} !== 9'h008 || bz8 !== 1'b0) begin
      nbad++;
      $display("FAIL busy_ignore_after: dones=%0d res=%h busy=%b",
               dc, {co8, y8}, bz8);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; c8 = 0; st8 = 1;
    @(posedge clk);
    #1 st8 = 0;
    k = 0;
    while (dn8 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (k != 9 || {co8, y8} !== 9'h003) begin
      nbad++;
      $display("FAIL b2b_first: k=%0d res=%h want 9/003", k, {co8, y8});
    end
    a8 = 8'h80; b8 = 8'h80; c8 = 0; st8 = 1;
    @(posedge clk);
    #1 st8 = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dn8 !== 1'b1 && k < 20);
    nvec++;
    if (k != 9 || {co8, y8} !== 9'h100) begin
      nbad++;
      $display("FAIL b2b_second: k=%0d res=%h want 9/100", k, {co8, y8});
    end
  endtask

  task automatic test_abort();
    int dc;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; c8 = 1; st8 = 1;
    @(posedge clk);
    #1 st8 = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    nvec++;
    if ({bz8, dn8, co8, y8} !== 11'd0) begin
      nbad++;
      $display("FAIL abort_reset: got %b want 0", {bz8, dn8, co8, y8});
    end
    dc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dn8 || bz8) dc++;
    end
    nvec++;
    if (dc != 0 || {co8, y8} !== 9'h000) begin
      nbad++;
      $display("FAIL abort_quiet: activity=%0d res=%h want 0/000",
               dc, {co8, y8});
    end
  endtask

  task automatic test_exhaustive(input int w);
    logic [8:0] r, e;
    int lat, dc, bc;
    for (int i = 0; i < (1 << (2 * w + 1)); i++) begin
      logic [7:0] a, b;
      logic ci;
      a = 8'(i & ((1 << w) - 1));
      b = 8'((i >> w) & ((1 << w) - 1));
      ci = 1'((i >> (2 * w)) & 1);
      e = model(w, a, b, ci);
      run(w, a, b, ci, r, lat, dc, bc);
      nvec++;
      if (r !== e || lat != w + 1 || dc != 1 || bc != w) begin
        nbad++;
        $display("FAIL exh_w%0d a=%h b=%h c=%b: res=%h lat=%0d dn=%0d want %h",
                 w, a, b, ci, r, lat, dc, e);
      end
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 150; i++) begin
      check8("random8", 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_exhaustive(4);
    test_exhaustive(1);
    test_random8();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
